// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO controller.
// Holds the default window base, register offsets and the decoded-register
// enumeration used by the address decoder.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEF   = 32'h8000_0000;
  localparam logic [31:0] UART_STRIDE_DEF = 32'h0000_0100;

  // Per-channel offsets (from channel base)
  localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
  localparam logic [31:0] OFF_RX      = 32'h0000_0004;
  localparam logic [31:0] OFF_TX      = 32'h0000_0008;

  // Global offsets (from MMIO_BASE)
  localparam logic [31:0] OFF_CYCLE   = 32'h0000_0010;
  localparam logic [31:0] OFF_INSTRET = 32'h0000_0014;
  localparam logic [31:0] OFF_CNT_RST = 32'h0000_0018;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_RX,
    REG_TX,
    REG_CYCLE,
    REG_INSTRET,
    REG_CNTRST,
    REG_NONE
  } mmio_reg_e;

endpackage

// File: rtl/mmio_ctrl_n_if.sv
// UART channel bundle between the MMIO controller and N UART channels.
// master: controller side (drives TX byte/valid and RX consume pulse).
// slave : UART side (drives TX ready, RX byte/valid).
// Channel c occupies bit c of the 1-bit vectors and [8c+7:8c] of the bytes.
interface mmio_ctrl_n_if #(
  parameter int unsigned N_UART = 1
);

  logic [8*N_UART-1:0] tx_data;
  logic [N_UART-1:0]   tx_valid;
  logic [N_UART-1:0]   tx_ready;
  logic [8*N_UART-1:0] rx_data;
  logic [N_UART-1:0]   rx_valid;
  logic [N_UART-1:0]   rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/mmio_counter.sv
// Free-running counter with increment enable and synchronous clear.
// Ports: clk, rst (sync, active-high), inc, clr (wins over inc), cnt.
// Wraps from all-ones to zero.
module mmio_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Next count: clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mmio_ctrl_n.sv
// Memory-mapped I/O controller for the 3-stage core: decodes EX-stage
// loads/stores against the MMIO window, serves N UART channels, keeps the
// cycle/instret counters and registers read data into MEM/WB.
// Ports: clk, rst (sync, active-high); ex_* EX-stage access; inst_retire;
// is_mmio (comb decode hit); rdata/rdata_sel (registered MEM/WB read);
// uart (channel bundle, master side).
module mmio_ctrl_n
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF,
  parameter int unsigned N_UART      = 1,
  parameter logic [31:0] UART_STRIDE = UART_STRIDE_DEF,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          ex_stall,
  input  logic          ex_load,
  input  logic          ex_store,
  input  logic [31:0]   ex_addr,
  input  logic [31:0]   ex_wdata,
  input  logic          inst_retire,
  output logic          is_mmio,
  output logic [31:0]   rdata,
  output logic          rdata_sel,
  mmio_ctrl_n_if.master uart
);

  localparam logic [31:0] WIN_SIZE = 32'(N_UART) * UART_STRIDE;

  mmio_reg_e           reg_id;
  logic [N_UART-1:0]   ch_oh;
  logic [31:0]         win_off;
  logic                in_win;
  logic                ld_acc;
  logic                st_acc;
  logic                cnt_clr;
  logic [31:0]         rd_val;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;

  logic [31:0]         rdata_d, rdata_q;
  logic                rdata_sel_d, rdata_sel_q;
  logic [8*N_UART-1:0] tx_data_d, tx_data_q;

  logic                unused_wdata_hi;
  assign unused_wdata_hi = ^ex_wdata[31:8];

  // Address decode; global registers take precedence over channel offsets
  always_comb begin
    reg_id = REG_NONE;
    ch_oh  = '0;
    if (ex_addr == MMIO_BASE + OFF_CYCLE) begin
      reg_id = REG_CYCLE;
    end else if (ex_addr == MMIO_BASE + OFF_INSTRET) begin
      reg_id = REG_INSTRET;
    end else if (ex_addr == MMIO_BASE + OFF_CNT_RST) begin
      reg_id = REG_CNTRST;
    end else begin
      for (int unsigned c = 0; c < N_UART; c++) begin
        if (reg_id == REG_NONE) begin
          if (ex_addr == MMIO_BASE + 32'(c) * UART_STRIDE + OFF_CTRL) begin
            reg_id   = REG_CTRL;
            ch_oh[c] = 1'b1;
          end else if (ex_addr == MMIO_BASE + 32'(c) * UART_STRIDE + OFF_RX) begin
            reg_id   = REG_RX;
            ch_oh[c] = 1'b1;
          end else if (ex_addr == MMIO_BASE + 32'(c) * UART_STRIDE + OFF_TX) begin
            reg_id   = REG_TX;
            ch_oh[c] = 1'b1;
          end
        end
      end
    end
  end

  assign is_mmio = (reg_id != REG_NONE);

  // Window membership, used to steer unmapped in-window loads to rdata = 0
  assign win_off = ex_addr - MMIO_BASE;
  assign in_win  = is_mmio || ((ex_addr >= MMIO_BASE) && (win_off < WIN_SIZE));

  // Qualified accesses; reset discards the in-flight access
  assign ld_acc  = ex_valid & ~ex_stall & ex_load & ~rst;
  assign st_acc  = ex_valid & ~ex_stall & ex_store & ~rst;
  assign cnt_clr = st_acc & (reg_id == REG_CNTRST);

  // Handshake pulses: ch_oh is one-hot or zero, so at most one channel fires
  assign uart.rx_ready = (ld_acc && reg_id == REG_RX) ? ch_oh : '0;
  assign uart.tx_valid = (st_acc && reg_id == REG_TX) ? ch_oh : '0;

  // TX byte shows the new write in its cycle and holds it afterwards
  always_comb begin
    tx_data_d = tx_data_q;
    for (int unsigned c = 0; c < N_UART; c++) begin
      if (uart.tx_valid[c]) begin
        tx_data_d[8*c +: 8] = ex_wdata[7:0];
      end
    end
  end

  assign uart.tx_data = tx_data_d;

  // Read mux; write-only and unmapped registers read as zero
  always_comb begin
    rd_val = '0;
    unique case (reg_id)
      REG_CYCLE:   rd_val = 32'(cycle_cnt);
      REG_INSTRET: rd_val = 32'(instret_cnt);
      REG_CTRL: begin
        for (int unsigned c = 0; c < N_UART; c++) begin
          if (ch_oh[c]) rd_val = {30'b0, uart.rx_valid[c], uart.tx_ready[c]};
        end
      end
      REG_RX: begin
        for (int unsigned c = 0; c < N_UART; c++) begin
          if (ch_oh[c]) rd_val = {24'b0, uart.rx_data[8*c +: 8]};
        end
      end
      default:     rd_val = '0;
    endcase
  end

  assign rdata_sel_d = ld_acc & in_win;
  assign rdata_d     = rdata_sel_d ? rd_val : '0;

  // MEM/WB read register holds while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q     <= '0;
      rdata_sel_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_data_q <= tx_data_d;
      if (!ex_stall) begin
        rdata_q     <= rdata_d;
        rdata_sel_q <= rdata_sel_d;
      end
    end
  end

  assign rdata     = rdata_q;
  assign rdata_sel = rdata_sel_q;

  mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .clr (cnt_clr),
    .cnt (cycle_cnt)
  );

  mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret (
    .clk (clk),
    .rst (rst),
    .inc (inst_retire),
    .clr (cnt_clr),
    .cnt (instret_cnt)
  );

endmodule

// File: doc/mmio_ctrl_n.md
Name: mmio_ctrl_n

Overview:
Parametrised memory-mapped I/O controller for the 3-stage RISC-V core. It decodes EX-stage load/store addresses against the MMIO window and serves N UART channels through ready/valid handshakes. It also maintains the cycle and retired-instruction counters, and registers read data into the MEM/WB stage. It replaces the fixed single-UART MMIO decode in the core controller with a channel-scalable block.

Parameters:
MMIO_BASE, 32'h8000_0000, base address of the MMIO window
N_UART, 1, number of UART channels (1..4)
UART_STRIDE, 32'h0000_0100, address spacing between channels; channel c base = MMIO_BASE + c*UART_STRIDE
CNT_WIDTH, 32, width of the cycle and instret counters (<=32; zero-extended on read)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX instruction is real (not bubble/flushed)
ex_stall  in  1  pipeline held this cycle; suppresses all side effects
ex_load  in  1  EX instruction is a load
ex_store  in  1  EX instruction is a store
ex_addr  in  32  ALU-computed effective address
ex_wdata  in  32  store data after forwarding
inst_retire  in  1  one instruction retired this cycle
is_mmio  out  1  comb: ex_addr falls in a mapped MMIO register; core must suppress DMem write enable
rdata  out  32  registered MMIO read data for MEM/WB
rdata_sel  out  1  registered: MEM/WB load was MMIO; WB muxes rdata instead of DMem
tx_data  out  8*N_UART  per-channel TX byte, channel c in [8c+7:8c]
tx_valid  out  N_UART  per-channel TX valid pulse
tx_ready  in  N_UART  per-channel TX ready
rx_data  in  8*N_UART  per-channel RX byte
rx_valid  in  N_UART  per-channel RX valid
rx_ready  out  N_UART  per-channel RX consume pulse

Behaviour:
- Per-channel map (offset from channel base): 0x00 CTRL (R) = {30'b0, rx_valid[c], tx_ready[c]}; 0x04 RX (R) = {24'b0, rx_data[c]}; 0x08 TX (W).
- Global map (offset from MMIO_BASE): 0x10 CYCLE (R); 0x14 INSTRET (R); 0x18 CNT_RST (W, data ignored). With N_UART=1, addresses match the existing map exactly.
- A global offset that collides with a channel offset goes to the global register.
- Access enable: acc = ex_valid & ~ex_stall & (ex_load | ex_store). is_mmio is asserted for any mapped address regardless of acc.
- RX read: with acc & ex_load at an RX address, rx_ready[c] = 1 combinationally in the same cycle. Data is latched into rdata at the next clk. Reading with rx_valid[c]=0 returns {24'b0, rx_data[c]} without error. Software must poll CTRL first.
- TX write: with acc & ex_store at a TX address, tx_valid[c] = 1 and tx_data[c] = ex_wdata[7:0] in that cycle. tx_data holds the last written value between writes. If tx_ready[c]=0 the byte is dropped; there is no buffering.
- Wrong direction (store to a read-only register, load from TX or CNT_RST) and unmapped addresses in the window: rdata = 0, rdata_sel = 1 for a load, no side effects.
- Read latency: 1 cycle. rdata and rdata_sel update every non-stalled cycle. A non-MMIO or non-load access sets rdata_sel = 0. While ex_stall = 1, rdata and rdata_sel hold.
- Counters: CYCLE increments every cycle; INSTRET increments when inst_retire = 1. Both wrap 2^CNT_WIDTH-1 -> 0.
- CNT_RST write: both counters read 0 on the next cycle. Clear wins over a simultaneous increment. A read of CYCLE in the cycle of the clear returns the pre-clear value.
- Reset values: CYCLE = 0, INSTRET = 0, rdata = 0, rdata_sel = 0, tx_data = 0. tx_valid and rx_ready are 0 during rst.
- Reset mid-access: the in-flight access is discarded and no handshake pulse is emitted.
- Only one channel may pulse per cycle; tx_valid and rx_ready are one-hot or zero.

Decomposition:
- Package mmio_pkg: MMIO_BASE default, offsets OFF_CTRL=0x00, OFF_RX=0x04, OFF_TX=0x08, OFF_CYCLE=0x10, OFF_INSTRET=0x14, OFF_CNT_RST=0x18, and a decoded-register enumeration {REG_CTRL, REG_RX, REG_TX, REG_CYCLE, REG_INSTRET, REG_CNTRST, REG_NONE}.
- Sub-module mmio_counter: CNT_WIDTH-bit counter with inc and clr inputs (clr priority, synchronous rst). Instantiated twice.

Test Plan:
- Reset, then 10 idle cycles with no retires; load MMIO_BASE+0x10 -> rdata = 10 one cycle later; load +0x14 -> 0.
- N_UART=2, rx_valid=2'b10, rx_data[15:8]=8'hA5; load MMIO_BASE+0x104 -> rx_ready=2'b10 for one cycle only; rdata = 32'h0000_00A5, rdata_sel = 1.
- Store 32'h1234_5641 to MMIO_BASE+0x08 with tx_ready[0]=1 -> tx_valid=01 for one cycle, tx_data[7:0]=8'h41, is_mmio=1. Repeat with ex_valid=0 -> no pulse.
- Store to +0x18 in the same cycle as inst_retire=1 with INSTRET=7 -> next cycle CYCLE=0 and INSTRET=0.
- Load +0x04 with ex_stall=1 for 3 cycles, then ex_stall=0 -> rx_ready pulses once, in the release cycle only; rdata holds its previous value during the stall.
- Preload CYCLE to 32'hFFFF_FFFF (force), advance one cycle -> CYCLE = 0. Load unmapped MMIO_BASE+0x40 -> rdata = 0, no pulses.
